// File: rtl/ddr2_i2c_master_if.sv
// ddr2_i2c_master_if: Avalon-MM register port plus open-drain I2C pin signals of ddr2_i2c_master.
//   address/chipselect/write_n/read_n/writedata/readdata : Avalon-MM slave register access
//   scl_in/sda_in   : pin levels seen on the bus
//   scl_oe/sda_oe   : 1 pulls the line low, 0 releases it
interface ddr2_i2c_master_if;
    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
    logic       read_n;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       scl_in;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;
    modport slave (
        input  address, chipselect, write_n, read_n, writedata, scl_in, sda_in,
        output readdata, scl_oe, sda_oe
    );
    modport master (
        output address, chipselect, write_n, read_n, writedata, scl_in, sda_in,
        input  readdata, scl_oe, sda_oe
    );
endinterface

// File: rtl/ddr2_i2c_master.sv
// ddr2_i2c_master: byte-level I2C master (START / 8-bit WR or RD with ACK / STOP) for the DDR2 SPD bus.
//   clk, reset_n : system clock, asynchronous active-low reset
//   bus          : Avalon-MM registers (0: TX/RX, 1: CMD, 2: STATUS) and open-drain SCL/SDA pins
//   CLK_DIV      : clk cycles per SCL quarter-period
module ddr2_i2c_master #(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic reset_n,
    ddr2_i2c_master_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, BYTE, STOP} state_t;
    state_t      state, ph_next, first_ph;
    logic [15:0] cnt;
    logic [1:0]  q;
    logic [3:0]  bitn, bit_next;
    logic [7:0]  tx, rx, status, readdata;
    logic        busy, done, rx_ack, stop_f, wr_f, rd_f, ack_out;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl_oe, sda_oe, accept, advance;

    // Line levels {scl_oe, sda_oe} to apply on entry to quarter qq of phase s; cur holds lines a quarter leaves alone.
    function automatic logic [1:0] lines(state_t s, logic [1:0] qq, logic [3:0] b, logic wr, logic ack,
                                         logic [7:0] t, logic [1:0] cur);
        logic d;
        d = wr ? (b < 4'd8 && !t[3'd7 - b[2:0]]) : (b == 4'd8 && !ack);
        case (s)
            START:   lines = qq == 2'd0 ? 2'b00 : qq == 2'd2 ? {cur[1], 1'b1} : qq == 2'd3 ? {1'b1, cur[0]} : cur;
            BYTE:    lines = qq == 2'd0 ? {1'b1, d} : qq == 2'd2 ? {1'b0, cur[0]} : cur;
            STOP:    lines = qq == 2'd0 ? 2'b11 : qq == 2'd1 ? {1'b0, cur[0]} : qq == 2'd3 ? {cur[1], 1'b0} : cur;
            default: lines = cur;
        endcase
    endfunction

    assign status   = {5'd0, rx_ack, done, busy};
    assign accept   = bus.chipselect && !bus.write_n && !busy && bus.address == 2'd1 && |bus.writedata[3:0];
    assign first_ph = bus.writedata[0] ? START : (bus.writedata[2] || bus.writedata[3]) ? BYTE : STOP;
    // A quarter only ends once a released SCL is actually seen high (clock stretching).
    assign advance  = cnt == 16'd0 && (scl_oe || scl_sync[1]);
    assign bit_next = (state == BYTE && bitn != 4'd8) ? bitn + 4'd1 : 4'd0;
    assign ph_next  = state == START ? ((wr_f || rd_f) ? BYTE : stop_f ? STOP : IDLE)
                    : (state == BYTE && bitn != 4'd8) ? BYTE
                    : (state == BYTE && stop_f) ? STOP : IDLE;
    assign bus.scl_oe   = scl_oe;
    assign bus.sda_oe   = sda_oe;
    assign bus.readdata = readdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            q        <= 2'd0;
            bitn     <= 4'd0;
            tx       <= 8'd0;
            rx       <= 8'd0;
            readdata <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_ack   <= 1'b1;
            stop_f   <= 1'b0;
            wr_f     <= 1'b0;
            rd_f     <= 1'b0;
            ack_out  <= 1'b0;
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_in};
            sda_sync <= {sda_sync[0], bus.sda_in};
            if (bus.chipselect && !bus.read_n)
                readdata <= bus.address == 2'd0 ? rx : bus.address == 2'd2 ? status : 8'd0;
            if (bus.chipselect && !bus.write_n && !busy && bus.address == 2'd0)
                tx <= bus.writedata;
            if (state == IDLE) begin
                if (accept) begin
                    busy    <= 1'b1;
                    done    <= 1'b0;
                    stop_f  <= bus.writedata[1];
                    wr_f    <= bus.writedata[2];
                    rd_f    <= bus.writedata[3] && !bus.writedata[2];
                    ack_out <= bus.writedata[4];
                    state   <= first_ph;
                    q       <= 2'd0;
                    bitn    <= 4'd0;
                    cnt     <= 16'(CLK_DIV - 1);
                    {scl_oe, sda_oe} <= lines(first_ph, 2'd0, 4'd0, bus.writedata[2], bus.writedata[4], tx,
                                              {scl_oe, sda_oe});
                end
            end else if (cnt != 16'd0) begin
                cnt <= cnt - 16'd1;
            end else if (advance) begin
                cnt <= 16'(CLK_DIV - 1);
                q   <= q + 2'd1;
                if (q != 2'd3) begin
                    {scl_oe, sda_oe} <= lines(state, q + 2'd1, bitn, wr_f, ack_out, tx, {scl_oe, sda_oe});
                end else begin
                    if (state == BYTE && bitn == 4'd8 && wr_f)
                        rx_ack <= sda_sync[1];
                    if (state == BYTE && bitn != 4'd8 && rd_f)
                        rx <= {rx[6:0], sda_sync[1]};
                    state <= ph_next;
                    bitn  <= bit_next;
                    if (ph_next == IDLE) begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        // a byte ends by pulling SCL low; it stays low until the next command
                        scl_oe <= scl_oe || state == BYTE;
                    end else begin
                        {scl_oe, sda_oe} <= lines(ph_next, 2'd0, bit_next, wr_f, ack_out, tx, {scl_oe, sda_oe});
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ddr2_i2c_master.sv
// tb_ddr2_i2c_master: directed self-checking bench for ddr2_i2c_master with a behavioural I2C slave.
//   Drives the Avalon registers, models the open-drain pins, and checks line sequences, timing and status.
module tb_ddr2_i2c_master;
    localparam int CLK_DIV = 4;
    localparam logic [1:0] M_NONE = 2'd0, M_ACK = 2'd1, M_READ = 2'd2;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   passed = 0, total = 0;

    ddr2_i2c_master_if bus();
    ddr2_i2c_master #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    // Open-drain pins: the slave may pull SDA low, and may hold SCL low while stretching.
    logic       s_pull = 1'b0, stretch_req = 1'b0;
    int         rises = 0, st_left = 50;
    logic       scl, sda;
    assign scl = ~bus.scl_oe & ~(stretch_req && rises == 4 && st_left > 0);
    assign sda = ~bus.sda_oe & ~s_pull;
    assign bus.scl_in = scl;
    assign bus.sda_in = sda;

    always @(posedge bus.scl_oe) if (stretch_req) rises++;
    always @(posedge clk) if (stretch_req && rises == 4 && !bus.scl_oe && st_left > 0) st_left--;

    // Slave: counts SCL rising edges per byte, captures SDA, ACKs writes or drives read data.
    logic [1:0] mode = M_NONE;
    logic [7:0] rd_byte = 8'h00, got = 8'h00;
    logic       ack_seen = 1'b0, pscl = 1'b1, psda = 1'b1;
    int         nbits = 0, stops = 0;
    always @(scl or sda) begin
        if (scl && pscl && psda && !sda) begin
            nbits = 0;
        end else if (scl && pscl && !psda && sda) begin
            nbits = 0;
            stops++;
        end else if (scl && !pscl) begin
            if (nbits < 8) got = {got[6:0], sda};
            else if (nbits == 8) ack_seen = sda;
            nbits++;
        end else if (!scl && pscl) begin
            s_pull = (mode == M_ACK) ? (nbits == 8)
                   : (mode == M_READ && nbits < 8) ? !rd_byte[3'(7 - nbits)] : 1'b0;
        end
        pscl = scl;
        psda = sda;
    end

    task automatic av_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.read_n = 1'b0;
        @(negedge clk);
        d = bus.readdata;
        bus.chipselect = 1'b0; bus.read_n = 1'b1;
    endtask

    // Keeps a STATUS read open; readdata lags busy by one cycle, so counting busy samples counts busy cycles.
    task automatic wait_idle(output int n, output logic [7:0] st);
        n = 0;
        bus.address = 2'd2; bus.chipselect = 1'b1; bus.read_n = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!bus.readdata[0]) break;
            n++;
        end
        st = bus.readdata;
        bus.chipselect = 1'b0; bus.read_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        bit found;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        av_read(2'd2, d);
        total++; if (d !== 8'h04) $display("FAIL reset_status: got %h expected 04", d); else passed++;
        av_read(2'd0, d);
        total++; if (d !== 8'h00) $display("FAIL reset_rx: got %h expected 00", d); else passed++;
        total++; if ({bus.scl_oe, bus.sda_oe} !== 2'b00) $display("FAIL reset_lines: got %b expected 00", {bus.scl_oe, bus.sda_oe}); else passed++;
        mode = M_NONE;
        av_write(2'd0, 8'h00);
        av_write(2'd1, 8'h07);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            found = bus.scl_oe && bus.sda_oe;
        end
        total++; if (!found) $display("FAIL midbyte_both_low: got 0 expected 1"); else passed++;
        #2 reset_n = 1'b0;
        #1;
        total++; if ({bus.scl_oe, bus.sda_oe} !== 2'b00) $display("FAIL async_reset_release: got %b expected 00", {bus.scl_oe, bus.sda_oe}); else passed++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        av_read(2'd2, d);
        total++; if (d !== 8'h04) $display("FAIL after_abort_status: got %h expected 04", d); else passed++;
    endtask

    task automatic test_write_ack;
        int n, s0;
        logic [7:0] st;
        mode = M_ACK;
        s0 = stops;
        av_write(2'd0, 8'hA0);
        av_write(2'd1, 8'h07);
        wait_idle(n, st);
        total++; if (n !== 176) $display("FAIL wr_busy_cycles: got %0d expected 176", n); else passed++;
        total++; if (st !== 8'h02) $display("FAIL wr_status: got %h expected 02", st); else passed++;
        total++; if (got !== 8'hA0) $display("FAIL wr_bits: got %h expected a0", got); else passed++;
        total++; if (ack_seen !== 1'b0) $display("FAIL wr_ack_line: got %b expected 0", ack_seen); else passed++;
        total++; if (stops !== s0 + 1) $display("FAIL wr_stop: got %0d expected %0d", stops, s0 + 1); else passed++;
        total++; if ({bus.scl_oe, bus.sda_oe} !== 2'b00) $display("FAIL wr_idle_lines: got %b expected 00", {bus.scl_oe, bus.sda_oe}); else passed++;
    endtask

    task automatic test_nack;
        int n, s0;
        logic [7:0] st;
        mode = M_NONE;
        s0 = stops;
        av_write(2'd0, 8'h55);
        av_write(2'd1, 8'h07);
        wait_idle(n, st);
        total++; if (n !== 176) $display("FAIL nack_busy_cycles: got %0d expected 176", n); else passed++;
        total++; if (st !== 8'h06) $display("FAIL nack_status: got %h expected 06", st); else passed++;
        total++; if (got !== 8'h55) $display("FAIL nack_bits: got %h expected 55", got); else passed++;
        total++; if (stops !== s0 + 1) $display("FAIL nack_stop: got %0d expected %0d", stops, s0 + 1); else passed++;
    endtask

    task automatic test_read;
        int n, s0;
        logic [7:0] st, d;
        mode = M_READ;
        rd_byte = 8'h5C;
        s0 = stops;
        av_write(2'd1, 8'h1A);
        wait_idle(n, st);
        total++; if (n !== 160) $display("FAIL rd_busy_cycles: got %0d expected 160", n); else passed++;
        total++; if (st !== 8'h06) $display("FAIL rd_status: got %h expected 06", st); else passed++;
        av_read(2'd0, d);
        total++; if (d !== 8'h5C) $display("FAIL rd_rx: got %h expected 5c", d); else passed++;
        total++; if (ack_seen !== 1'b1) $display("FAIL rd_master_nack: got %b expected 1", ack_seen); else passed++;
        total++; if (stops !== s0 + 1) $display("FAIL rd_stop: got %0d expected %0d", stops, s0 + 1); else passed++;
        mode = M_NONE;
    endtask

    task automatic test_stretch;
        int n;
        logic [7:0] st;
        mode = M_ACK;
        stretch_req = 1'b1;
        av_write(2'd0, 8'h96);
        av_write(2'd1, 8'h07);
        wait_idle(n, st);
        stretch_req = 1'b0;
        total++; if (n < 224 || n > 228) $display("FAIL stretch_busy_cycles: got %0d expected 224..228", n); else passed++;
        total++; if (got !== 8'h96) $display("FAIL stretch_bits: got %h expected 96", got); else passed++;
        total++; if (st !== 8'h02) $display("FAIL stretch_status: got %h expected 02", st); else passed++;
    endtask

    task automatic test_busy;
        int n, s0;
        logic [7:0] st, d;
        mode = M_ACK;
        av_write(2'd0, 8'h3C);
        av_write(2'd1, 8'h07);
        repeat (40) @(negedge clk);
        av_write(2'd0, 8'hFF);
        av_write(2'd1, 8'h0B);
        wait_idle(n, st);
        total++; if (got !== 8'h3C) $display("FAIL busy_tx_protect: got %h expected 3c", got); else passed++;
        total++; if (st !== 8'h02) $display("FAIL busy_status: got %h expected 02", st); else passed++;
        repeat (20) @(negedge clk);
        av_read(2'd2, d);
        total++; if (d !== 8'h02) $display("FAIL busy_cmd_ignored: got %h expected 02", d); else passed++;
        s0 = stops;
        av_write(2'd1, 8'h0C);
        wait_idle(n, st);
        total++; if (n !== 144) $display("FAIL wr_wins_cycles: got %0d expected 144", n); else passed++;
        total++; if (got !== 8'h3C) $display("FAIL wr_wins_bits: got %h expected 3c", got); else passed++;
        total++; if (st !== 8'h02) $display("FAIL wr_wins_status: got %h expected 02", st); else passed++;
        total++; if (stops !== s0 || bus.scl_oe !== 1'b1) $display("FAIL no_stop_scl_low: got stops %0d scl_oe %b expected stops %0d scl_oe 1", stops, bus.scl_oe, s0); else passed++;
        av_write(2'd1, 8'h10);
        av_read(2'd2, d);
        total++; if (d !== 8'h02) $display("FAIL null_cmd: got %h expected 02", d); else passed++;
    endtask

    initial begin
        bus.address = 2'd0; bus.writedata = 8'h00;
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.read_n = 1'b1;
        #2;
        test_reset;
        test_write_ack;
        test_nack;
        test_read;
        test_stretch;
        test_busy;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ddr2_i2c_master.md
Name: ddr2_i2c_master

Overview:
Byte-level I2C master controller for the DDR2 SODIMM SPD/EEPROM bus. It replaces CPU bit-banging of the SCL/SDA GPIO slaves. It sequences START, 8-bit write or read with ACK, and STOP conditions on open-drain SCL/SDA, under an Avalon-MM slave register interface. It sits between the Nios-side Avalon fabric and the DDR2 I2C pins, which are tri-stated at the top level.

Parameters:
CLK_DIV, 125, clk cycles per SCL quarter-period (100 kHz SCL at 50 MHz clk); legal range 2..65535.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  Avalon register select
chipselect  in  1  Avalon chip select
write_n  in  1  Avalon write strobe, active low
read_n  in  1  Avalon read strobe, active low
writedata  in  8  Avalon write data
readdata  out  8  Avalon read data, registered
scl_in  in  1  SCL pin level
sda_in  in  1  SDA pin level
scl_oe  out  1  1 = pull SCL low, 0 = release
sda_oe  out  1  1 = pull SDA low, 0 = release

Behaviour:
- Reset: reset is reset_n, asynchronous, active-low; clock is clk. During reset: scl_oe=0, sda_oe=0, readdata=0, tx=0, rx=0, busy=0, done=0, rx_ack=1, state IDLE.
- Reset mid-transfer aborts immediately and releases both lines.
- Register map:
  - Addr 0, write: TX byte. Addr 0, read: RX byte.
  - Addr 1, write: CMD. bit0 START, bit1 STOP, bit2 WR, bit3 RD, bit4 ACK_OUT (0 = master ACKs a read byte, 1 = NACK).
  - Addr 2, read: STATUS. bit0 busy, bit1 done, bit2 rx_ack (slave ACK bit sampled on WR; 0 = ACK).
  - Other reads return 0.
- readdata is registered: valid the cycle after chipselect && ~read_n.
- CMD handling:
  - A CMD write is accepted only when busy=0. A CMD write while busy=1 is ignored.
  - Writes to TX while busy are ignored.
  - Accepting a CMD with any of bits 0..3 set: busy=1 and done=0 on the next cycle.
  - A CMD with bits 0..3 all zero is ignored.
  - If WR and RD are both set, WR wins and RD is ignored.
- Sequence: the START phase runs if START is set, then the byte phase if WR or RD is set, then the STOP phase if STOP is set.
- At completion: busy=0 and done=1, holding until the next accepted CMD.
- Inputs: scl_in and sda_in pass through 2-flop synchronizers before use.
- Timing: a quarter tick is produced by a down-counter reloaded with CLK_DIV-1; the counter is reset at each phase entry. Every phase is 4 quarters, Q0..Q3.
- START phase:
  - Q0: release SDA and SCL.
  - Q1: hold.
  - Q2: pull SDA low.
  - Q3: pull SCL low.
- Bit slot (9 slots per byte: 8 data bits MSB first, then the ACK slot):
  - Q0: SCL low; drive SDA (sda_oe = ~bit).
  - Q1: SCL low.
  - Q2: release SCL.
  - Q3: SCL still released; at the end of Q3, sample SDA and pull SCL low.
- Clock stretching: after SCL is released, the quarter counter holds while synchronized scl_in=0. The phase resumes counting once scl_in=1.
- WR byte: SDA carries tx[7:0]. In the ACK slot SDA is released and the sample is stored in rx_ack.
- RD byte: SDA is released for the 8 data bits and samples shift into rx. In the ACK slot sda_oe = ~ACK_OUT.
- STOP phase:
  - Q0: SCL low, SDA low.
  - Q1: release SCL.
  - Q2: hold.
  - Q3: release SDA.
- Idle line state after STOP: both released. Without STOP: SCL stays low, SDA stays at its last driven value, ready for the next command (repeated START releases SDA first in Q0).
- Phase durations: START = 4*CLK_DIV cycles, byte = 36*CLK_DIV cycles, STOP = 4*CLK_DIV cycles, each excluding stretch time.
- No arbitration-loss detection (single master).

Test Plan:
- Reset: assert reset_n=0 mid-byte -> scl_oe=sda_oe=0 the same cycle; after release, STATUS reads 0x04.
- Write with ACK, CLK_DIV=4: TX=0xA0, CMD=0x07, slave model ACKs -> SDA bits 1,0,1,0,0,0,0,0 sampled at SCL rising edges; busy high for 176 cycles; STATUS=0x02.
- NACK: same as above with no slave -> STATUS=0x06 (done, rx_ack=1); STOP is still issued.
- Read byte: CMD=0x1A, slave drives 0x5C -> RX=0x5C; SDA released in the ACK slot (NACK); STOP follows; 160 cycles.
- Clock stretch: slave holds SCL low 50 cycles in bit 3 -> the byte lengthens by exactly 50 cycles (±2 for synchronizer latency); data is intact.
- Busy protection: a CMD write and a TX write during a transfer -> both ignored, TX unchanged. Then WR and RD both set (CMD=0x0C) -> a write is performed. CMD=0x10 -> busy stays 0.
